// File: rtl/freq_cfg_loader.sv
// freq_cfg_loader: validates a requested (period, duty) pair and programs the
// adjustable frequency divider through LOAD_D / LOAD_P / PAR_LOAD, duty first.
// Optionally waits for the divider's period boundary (p_active==0) first.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_valid/period/duty      request handshake input
//   cfg_ready                  loader idle, can accept a request
//   p_active                   divider period counter running (0 = at boundary)
//   LOAD_D, LOAD_P, PAR_LOAD   divider load strobes and parallel-load value
//   cfg_done, cfg_err          one-cycle completion / rejection pulses
//   sync_forced                sticky: last load was forced by sync timeout
//   cur_period, cur_duty       shadow of the values held by the divider
module freq_cfg_loader #(
  parameter bit          SYNC_TO_PERIOD = 1'b1,
  parameter int unsigned SYNC_TIMEOUT   = 15,
  parameter int unsigned SETTLE_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_period,
  input  logic [2:0] cfg_duty,
  output logic       cfg_ready,
  input  logic       p_active,
  output logic       LOAD_D,
  output logic       LOAD_P,
  output logic [2:0] PAR_LOAD,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       sync_forced,
  output logic [2:0] cur_period,
  output logic [2:0] cur_duty
);

  localparam int unsigned W  = 3;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SYNC_LAST   = CW'(SYNC_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, LD_DUTY, LD_PER, SETTLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  req_period, req_period_n;
  logic [W-1:0]  req_duty, req_duty_n;
  logic [W-1:0]  cur_period_n, cur_duty_n;
  logic          forced_n, done_n, err_n;
  logic          load_d_n, load_p_n, ready_n;
  logic [W-1:0]  par_n;

  // Next state plus next values of every registered output.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    req_period_n = req_period;
    req_duty_n   = req_duty;
    cur_period_n = cur_period;
    cur_duty_n   = cur_duty;
    forced_n     = sync_forced;
    done_n       = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          req_period_n = cfg_period;
          req_duty_n   = cfg_duty;
          forced_n     = 1'b0;
          cnt_n        = '0;
          if (cfg_period < W'(2) || cfg_period <= cfg_duty) begin
            err_n = 1'b1;
          end else if (cfg_period == cur_period && cfg_duty == cur_duty) begin
            done_n = 1'b1;
          end else begin
            state_n = SYNC_TO_PERIOD ? SYNC : LD_DUTY;
          end
        end
      end
      SYNC: begin
        // Boundary wins over timeout when both happen on the same edge.
        if (!p_active) begin
          state_n = LD_DUTY;
        end else if (cnt == SYNC_LAST) begin
          forced_n = 1'b1;
          state_n  = LD_DUTY;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_n = cnt + CW'(1);
        end
      end
      LD_DUTY: begin
        cur_duty_n = req_duty;
        state_n    = LD_PER;
      end
      LD_PER: begin
        cur_period_n = req_period;
        cnt_n        = '0;
        if (SETTLE_CYCLES == 0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with it.
    load_d_n = (state_n == LD_DUTY);
    load_p_n = (state_n == LD_PER);
    ready_n  = (state_n == IDLE);
    par_n    = load_d_n ? req_duty_n : (load_p_n ? req_period_n : '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_period  <= '0;
      req_duty    <= '0;
      cur_period  <= '0;
      cur_duty    <= '0;
      sync_forced <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      LOAD_D      <= 1'b0;
      LOAD_P      <= 1'b0;
      PAR_LOAD    <= '0;
      cfg_ready   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      req_period  <= req_period_n;
      req_duty    <= req_duty_n;
      cur_period  <= cur_period_n;
      cur_duty    <= cur_duty_n;
      sync_forced <= forced_n;
      cfg_done    <= done_n;
      cfg_err     <= err_n;
      LOAD_D      <= load_d_n;
      LOAD_P      <= load_p_n;
      PAR_LOAD    <= par_n;
      cfg_ready   <= ready_n;
    end
  end

endmodule
